clip_vertex_reader: RTL and testbench

//  Consumer end of the clip-space vertex buffer filled by the MVP transform stage (4 words/vertex: x,y,z,w, Q16.16 signed).

---
 rtl/clip_vertex_reader.sv | 208 ++++++++++++++++++++
 tb/tb_clip_vertex_reader.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/clip_vertex_reader.sv
// clip_vertex_reader
//   Reads the clip-space vertex buffer (x,y,z,w per vertex, Q16.16 signed). For each vertex it
//   does the perspective divide (x/w, y/w) with one shared restoring divider, maps the result to
//   integer screen coordinates, and hands one screen vertex per valid/ready handshake downstream.
// Ports
//   clock, reset          : single clock, synchronous active-high reset
//   start, count          : begin a pass over 'count' vertices (sampled only while idle)
//   done                  : high while idle
//   mem_read_addr/_data   : registered word address; data returns one cycle later
//   out_valid/out_ready   : output handshake
//   out_x, out_y          : screen coordinates (row 0 = top)
//   out_culled            : vertex behind the eye or outside NDC [-1,1]
//   out_index             : vertex number within the pass
module clip_vertex_reader #(
  parameter int SCREEN_W  = 320,
  parameter int SCREEN_H  = 240,
  parameter int FRAC_BITS = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] count,
  output logic        done,
  output logic [31:0] mem_read_addr,
  input  logic [31:0] mem_read_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_x,
  output logic [15:0] out_y,
  output logic        out_culled,
  output logic [31:0] out_index
);

  localparam int DW = 32 + FRAC_BITS;
  localparam logic signed [31:0] ONE = 32'sd1 <<< FRAC_BITS;
  localparam logic [DW-1:0] SAT = DW'(32'h7FFF_FFFF);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_FETCH_X, S_FETCH_Y, S_FETCH_Z, S_FETCH_W,
    S_CHECK, S_DIV_X, S_DIV_Y, S_MAP, S_OUT
  } state_t;

  state_t state, state_next;

  logic [31:0]        count_lat, idx;
  logic signed [31:0] vx, vy, vw, ndc_x, ndc_y;
  logic [31:0]        div_rem, div_d;
  logic [DW-1:0]      div_quo;
  logic               div_neg;
  logic [6:0]         div_cnt;
  logic               div_last, w_nonpos, last_vertex;

  assign div_last    = (div_cnt == 7'(DW - 1));
  assign w_nonpos    = (vw <= 32'sd0);
  assign last_vertex = ((idx + 32'd1) == count_lat);
  assign done        = (state == S_IDLE);
  assign out_valid   = (state == S_OUT);

  function automatic logic [31:0] mag32(input logic signed [31:0] v);
    return v[31] ? 32'(-v) : 32'(v);
  endfunction

  // One restoring-divide step plus the signed, saturated result of that step.
  logic [32:0]        trial;
  logic [31:0]        rem_step;
  logic [DW-1:0]      quo_step;
  logic [30:0]        quo_mag;
  logic signed [31:0] div_result;

  always_comb begin
    trial = {div_rem, div_quo[DW-1]};
    if (trial >= {1'b0, div_d}) begin
      rem_step = 32'(trial - {1'b0, div_d});
      quo_step = {div_quo[DW-2:0], 1'b1};
    end else begin
      rem_step = trial[31:0];
      quo_step = {div_quo[DW-2:0], 1'b0};
    end
    quo_mag    = (quo_step > SAT) ? 31'h7FFF_FFFF : quo_step[30:0];
    div_result = div_neg ? -$signed({1'b0, quo_mag}) : $signed({1'b0, quo_mag});
  end

  // Viewport mapping of the clamped NDC values.
  logic signed [31:0] cx, cy;
  logic [63:0]        px, py, sx, sy;
  logic [15:0]        sx16, sy16;
  logic               map_cull;

  always_comb begin
    cx = (ndc_x > ONE) ? ONE : ((ndc_x < -ONE) ? -ONE : ndc_x);
    cy = (ndc_y > ONE) ? ONE : ((ndc_y < -ONE) ? -ONE : ndc_y);
    px = {32'd0, 32'(cx + ONE)} * 64'(SCREEN_W);
    py = {32'd0, 32'(ONE - cy)} * 64'(SCREEN_H);
    sx = px >> (FRAC_BITS + 1);
    sy = py >> (FRAC_BITS + 1);
    sx16 = (sx >= 64'(SCREEN_W)) ? 16'(SCREEN_W - 1) : sx[15:0];
    sy16 = (sy >= 64'(SCREEN_H)) ? 16'(SCREEN_H - 1) : sy[15:0];
    map_cull = (ndc_x > ONE) || (ndc_x < -ONE) || (ndc_y > ONE) || (ndc_y < -ONE);
  end

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (start && count != 32'd0) state_next = S_ADDR;
      S_ADDR:    state_next = S_FETCH_X;
      S_FETCH_X: state_next = S_FETCH_Y;
      S_FETCH_Y: state_next = S_FETCH_Z;
      S_FETCH_Z: state_next = S_FETCH_W;
      S_FETCH_W: state_next = S_CHECK;
      S_CHECK:   state_next = w_nonpos ? S_OUT : S_DIV_X;
      S_DIV_X:   if (div_last) state_next = S_DIV_Y;
      S_DIV_Y:   if (div_last) state_next = S_MAP;
      S_MAP:     state_next = S_OUT;
      S_OUT:     if (out_ready) state_next = last_vertex ? S_IDLE : S_ADDR;
      default:   state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_lat     <= '0;
      idx           <= '0;
      mem_read_addr <= '0;
      vx            <= '0;
      vy            <= '0;
      vw            <= '0;
      ndc_x         <= '0;
      ndc_y         <= '0;
      div_rem       <= '0;
      div_d         <= '0;
      div_quo       <= '0;
      div_neg       <= 1'b0;
      div_cnt       <= '0;
      out_x         <= '0;
      out_y         <= '0;
      out_culled    <= 1'b0;
      out_index     <= '0;
    end else begin
      case (state)
        S_IDLE: if (start && count != 32'd0) begin
          count_lat     <= count;
          idx           <= '0;
          mem_read_addr <= '0;
        end
        // Address leads captured data by one cycle; it stops at 4*idx+3 so no extra word is read.
        S_ADDR:    mem_read_addr <= mem_read_addr + 32'd1;
        S_FETCH_X: begin vx <= mem_read_data; mem_read_addr <= mem_read_addr + 32'd1; end
        S_FETCH_Y: begin vy <= mem_read_data; mem_read_addr <= mem_read_addr + 32'd1; end
        S_FETCH_W: vw <= mem_read_data;
        S_CHECK: begin
          if (w_nonpos) begin
            out_culled <= 1'b1;
            out_x      <= '0;
            out_y      <= '0;
            out_index  <= idx;
          end else begin
            div_rem <= '0;
            div_quo <= {mag32(vx), {FRAC_BITS{1'b0}}};
            div_d   <= mag32(vw);
            div_neg <= vx[31] ^ vw[31];
            div_cnt <= '0;
          end
        end
        // The final iteration's result is taken straight from the step logic, so the y divide
        // is loaded in the same cycle and each divide costs exactly DW cycles.
        S_DIV_X: begin
          if (div_last) begin
            ndc_x   <= div_result;
            div_rem <= '0;
            div_quo <= {mag32(vy), {FRAC_BITS{1'b0}}};
            div_neg <= vy[31] ^ vw[31];
            div_cnt <= '0;
          end else begin
            div_rem <= rem_step;
            div_quo <= quo_step;
            div_cnt <= div_cnt + 7'd1;
          end
        end
        S_DIV_Y: begin
          if (div_last) begin
            ndc_y <= div_result;
          end else begin
            div_rem <= rem_step;
            div_quo <= quo_step;
            div_cnt <= div_cnt + 7'd1;
          end
        end
        S_MAP: begin
          out_x      <= sx16;
          out_y      <= sy16;
          out_culled <= map_cull;
          out_index  <= idx;
        end
        S_OUT: if (out_ready && !last_vertex) begin
          idx           <= idx + 32'd1;
          mem_read_addr <= (idx + 32'd1) << 2;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_clip_vertex_reader.sv
module tb_clip_vertex_reader;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] count;
  logic        done;
  logic [31:0] mem_read_addr;
  logic [31:0] mem_read_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_x;
  logic [15:0] out_y;
  logic        out_culled;
  logic [31:0] out_index;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [0:15];
  logic [31:0] addr_log [$];
  logic [31:0] last_addr;
  logic        log_en = 1'b0;

  clip_vertex_reader #(.SCREEN_W(320), .SCREEN_H(240), .FRAC_BITS(16)) dut (
    .clock(clock), .reset(reset), .start(start), .count(count), .done(done),
    .mem_read_addr(mem_read_addr), .mem_read_data(mem_read_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
    .out_culled(out_culled), .out_index(out_index)
  );

  always #5 clock = ~clock;

  // One-cycle read latency buffer model
  always @(posedge clock) mem_read_data <= mem[mem_read_addr[3:0]];

  always @(posedge clock) begin
    if (log_en && mem_read_addr !== last_addr) begin
      addr_log.push_back(mem_read_addr);
      last_addr = mem_read_addr;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int maxc, output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < maxc) begin
      tick();
      n++;
    end
    chk("valid_timeout", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("valid_drop", {31'd0, out_valid}, 32'd0);
  endtask

  task automatic load_vertex(input int v, input logic [31:0] x, y, w);
    mem[4*v]   = x;
    mem[4*v+1] = 32'h1234_5678;
    mem[4*v+2] = y;
    mem[4*v+3] = w;
    mem[4*v+1] = y;
    mem[4*v+2] = 32'hDEAD_BEEF;
  endtask

  task automatic pulse_start(input logic [31:0] n);
    count = n;
    start = 1'b1;
    tick();
    start = 1'b0;
    count = 32'hFFFF_FFFF;
  endtask

  task automatic single(input string tag, input logic [31:0] x, y, w,
                        input logic [31:0] ex, ey, ec, input int exact_lat, input int max_lat);
    int n;
    load_vertex(0, x, y, w);
    pulse_start(32'd1);
    wait_valid(max_lat + 5, n);
    if (exact_lat >= 0) chk({tag, "_lat"}, n, exact_lat);
    else                chk({tag, "_lat_le"}, {31'd0, n <= max_lat}, 32'd1);
    chk({tag, "_x"}, {16'd0, out_x}, ex);
    chk({tag, "_y"}, {16'd0, out_y}, ey);
    chk({tag, "_culled"}, {31'd0, out_culled}, ec);
    chk({tag, "_index"}, out_index, 32'd0);
    chk({tag, "_busy"}, {31'd0, done}, 32'd0);
    handshake();
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
  endtask

  initial begin
    int n;
    int unstable;
    logic [15:0] hx, hy;
    logic        hc;
    logic [31:0] hi;

    for (int i = 0; i < 16; i++) mem[i] = '0;
    reset = 1'b1; start = 1'b0; count = '0; out_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_done", {31'd0, done}, 32'd1);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_addr", mem_read_addr, 32'd0);
    chk("rst_x", {16'd0, out_x}, 32'd0);
    chk("rst_y", {16'd0, out_y}, 32'd0);
    chk("rst_culled", {31'd0, out_culled}, 32'd0);
    chk("rst_index", out_index, 32'd0);

    // ndc (0.5,0.5) -> (240,60); full unculled latency
    single("t1", 32'h0000_8000, 32'h0000_8000, 32'h0001_0000, 32'd240, 32'd60, 32'd0, 103, 103);
    // ndc (-0.5,+0.5) -> (80,60), with out_ready held high while idle/busy
    out_ready = 1'b1;
    tick(); tick();
    chk("t2_pre_done", {31'd0, done}, 32'd1);
    out_ready = 1'b0;
    single("t2", 32'hFFFF_0000, 32'h0001_0000, 32'h0002_0000, 32'd80, 32'd60, 32'd0, 103, 103);
    // behind-eye vertices
    single("t3a", 32'h0000_8000, 32'h0000_8000, 32'h0000_0000, 32'd0, 32'd0, 32'd1, -1, 7);
    single("t3b", 32'h0000_8000, 32'h0000_8000, 32'hFFFF_0000, 32'd0, 32'd0, 32'd1, -1, 7);
    // outside NDC: clamped to the screen edges
    single("t4a", 32'h0003_0000, 32'h0000_0000, 32'h0001_0000, 32'd319, 32'd120, 32'd1, 103, 103);
    single("t4b", 32'hFFFD_0000, 32'h0000_0000, 32'h0001_0000, 32'd0, 32'd120, 32'd1, 103, 103);

    // three-vertex pass with backpressure on vertex 1
    load_vertex(0, 32'h0000_8000, 32'h0000_8000, 32'h0001_0000);  // (240,60)
    load_vertex(1, 32'hFFFF_0000, 32'hFFFF_0000, 32'h0002_0000);  // (80,180)
    load_vertex(2, 32'h0000_0000, 32'h0000_0000, 32'h0001_0000);  // (160,120)
    addr_log.delete();
    last_addr = mem_read_addr;
    log_en = 1'b1;
    pulse_start(32'd3);
    wait_valid(110, n);
    chk("t5_v0_x", {16'd0, out_x}, 32'd240);
    chk("t5_v0_y", {16'd0, out_y}, 32'd60);
    chk("t5_v0_index", out_index, 32'd0);
    handshake();
    chk("t5_v0_busy", {31'd0, done}, 32'd0);
    wait_valid(110, n);
    hx = out_x; hy = out_y; hc = out_culled; hi = out_index;
    unstable = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (out_valid !== 1'b1 || out_x !== hx || out_y !== hy || out_culled !== hc || out_index !== hi)
        unstable++;
    end
    chk("t5_hold_stable", unstable, 32'd0);
    chk("t5_v1_x", {16'd0, out_x}, 32'd80);
    chk("t5_v1_y", {16'd0, out_y}, 32'd180);
    chk("t5_v1_culled", {31'd0, out_culled}, 32'd0);
    chk("t5_v1_index", out_index, 32'd1);
    handshake();
    wait_valid(110, n);
    chk("t5_v2_x", {16'd0, out_x}, 32'd160);
    chk("t5_v2_y", {16'd0, out_y}, 32'd120);
    chk("t5_v2_index", out_index, 32'd2);
    chk("t5_v2_busy", {31'd0, done}, 32'd0);
    handshake();
    chk("t5_done", {31'd0, done}, 32'd1);
    tick(); tick();
    log_en = 1'b0;
    chk("t5_log_len", addr_log.size(), 32'd12);
    for (int i = 0; i < 12; i++) begin
      if (i < addr_log.size()) chk($sformatf("t5_addr%0d", i), addr_log[i], i);
    end

    // reset during the x divide, then a zero-count start
    load_vertex(0, 32'h0000_8000, 32'h0000_8000, 32'h0001_0000);
    pulse_start(32'd1);
    for (int c = 0; c < 20; c++) tick();
    chk("t6_mid_busy", {31'd0, done}, 32'd0);
    reset = 1'b1;
    tick();
    chk("t6_rst_done", {31'd0, done}, 32'd1);
    chk("t6_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("t6_rst_addr", mem_read_addr, 32'd0);
    reset = 1'b0;
    pulse_start(32'd0);
    unstable = 0;
    for (int c = 0; c < 20; c++) begin
      if (done !== 1'b1 || out_valid !== 1'b0 || mem_read_addr !== 32'd0) unstable++;
      tick();
    end
    chk("t6_count0_idle", unstable, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
